// File: rtl/rf_pkg.sv
// Shared register-file constants and the address-width helper used by decode
// and the multi-port register file.
package rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned ZERO_REG  = 0;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
// Issue beats writeback on the same register; flush beats issue.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NWR   = 2
)(
   input  logic                          CLK,
   input  logic                          rst_n,
   input  logic [NWR-1:0]                wr_en,
   input  logic [NWR*clog2(NREGS)-1:0]   wr_addr,
   input  logic                          iss_en,
   input  logic [clog2(NREGS)-1:0]       iss_addr,
   input  logic                          flush,
   output logic [NREGS-1:0]              busy_vec
);

   localparam int unsigned AW = clog2(NREGS);

   // Later non-blocking assignments win, so the issue set follows the clears.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec <= '0;
      end else if (flush) begin
         busy_vec <= '0;
      end else begin
         for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_en[k] && wr_addr[k*AW +: AW] != AW'(ZERO_REG))
               busy_vec[wr_addr[k*AW +: AW]] <= 1'b0;
         end
         if (iss_en && iss_addr != AW'(ZERO_REG))
            busy_vec[iss_addr] <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// busy scoreboard for RAW-hazard stalls. Register 0 reads zero.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter bit          BYPASS = 1'b1
)(
   input  logic                          CLK,
   input  logic                          rst_n,
   input  logic [NWR-1:0]                Wr_En,
   input  logic [NWR*clog2(NREGS)-1:0]   Wr_Addr,
   input  logic [NWR*XLEN-1:0]           Wr_Data,
   input  logic [NRD*clog2(NREGS)-1:0]   Rd_Addr,
   output logic [NRD*XLEN-1:0]           Rd_Data,
   output logic [NRD-1:0]                Rd_Busy,
   input  logic                          Iss_En,
   input  logic [clog2(NREGS)-1:0]       Iss_Addr,
   input  logic                          Flush,
   output logic [NREGS-1:0]              Busy_Vec
);

   localparam int unsigned AW = clog2(NREGS);

   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else begin
         for (int unsigned k = 0; k < NWR; k++) begin
            if (Wr_En[k] && Wr_Addr[k*AW +: AW] != AW'(ZERO_REG))
               mem[Wr_Addr[k*AW +: AW]] <= Wr_Data[k*XLEN +: XLEN];
         end
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR)
   ) u_sb (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .wr_en    (Wr_En),
      .wr_addr  (Wr_Addr),
      .iss_en   (Iss_En),
      .iss_addr (Iss_Addr),
      .flush    (Flush),
      .busy_vec (Busy_Vec)
   );

   for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] data;
      logic            hit;

      assign ra = Rd_Addr[r*AW +: AW];

      // Scan ports in ascending order so the highest-indexed writer wins.
      always_comb begin
         data = mem[ra];
         hit  = 1'b0;
         if (BYPASS) begin
            for (int unsigned k = 0; k < NWR; k++) begin
               if (Wr_En[k] && Wr_Addr[k*AW +: AW] == ra) begin
                  data = Wr_Data[k*XLEN +: XLEN];
                  hit  = 1'b1;
               end
            end
         end
      end

      assign Rd_Data[r*XLEN +: XLEN] = (ra == AW'(ZERO_REG)) ? '0 : data;
      assign Rd_Busy[r] = (ra != AW'(ZERO_REG)) && Busy_Vec[ra] && !hit;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a bypass and a non-bypass build share stimulus; expected
// outputs are queued at issue time and checked by an independent monitor.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic        flush;

   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic [31:0] bv_b, bv_n;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) u_byp (
      .CLK(clk), .rst_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Rd_Addr(rd_addr), .Rd_Data(rd_data_b), .Rd_Busy(rd_busy_b),
      .Iss_En(iss_en), .Iss_Addr(iss_addr), .Flush(flush), .Busy_Vec(bv_b));

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) u_nob (
      .CLK(clk), .rst_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Rd_Addr(rd_addr), .Rd_Data(rd_data_n), .Rd_Busy(rd_busy_n),
      .Iss_En(iss_en), .Iss_Addr(iss_addr), .Flush(flush), .Busy_Vec(bv_n));

   typedef struct {
      logic [63:0] d_b, d_n;
      logic [1:0]  b_b, b_n;
      logic [31:0] bv;
   } exp_t;

   exp_t        q[$];
   event        presented;
   int          vectors = 0;
   int          miscompares = 0;

   // Architectural model: plain arrays of register values and busy flags.
   logic [31:0] m_reg [32];
   bit          m_busy [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_bv();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic exp_t predict();
      exp_t e;
      for (int r = 0; r < 2; r++) begin
         int unsigned a;
         bit hit;
         logic [31:0] fwd;
         a   = rd_addr[r*5 +: 5];
         hit = 1'b0;
         fwd = '0;
         for (int k = 0; k < 2; k++)
            if (wr_en[k] && wr_addr[k*5 +: 5] == a) begin
               hit = 1'b1;
               fwd = wr_data[k*32 +: 32];
            end
         e.d_b[r*32 +: 32] = (a == 0) ? 32'd0 : (hit ? fwd : m_reg[a]);
         e.d_n[r*32 +: 32] = (a == 0) ? 32'd0 : m_reg[a];
         e.b_b[r] = (a != 0) && m_busy[a] && !hit;
         e.b_n[r] = (a != 0) && m_busy[a];
      end
      e.bv = model_bv();
      return e;
   endfunction

   function automatic void model_clock();
      for (int k = 0; k < 2; k++)
         if (wr_en[k] && wr_addr[k*5 +: 5] != 0) m_reg[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++)
            if (wr_en[k] && wr_addr[k*5 +: 5] != 0) m_busy[wr_addr[k*5 +: 5]] = 1'b0;
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
   endfunction

   task automatic apply(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic ie, input logic [4:0] ia, input logic fl);
      @(negedge clk);
      wr_en    = we;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      rd_addr  = {ra1, ra0};
      iss_en   = ie;
      iss_addr = ia;
      flush    = fl;
      q.push_back(predict());
      -> presented;
      @(posedge clk);
      model_clock();
   endtask

   task automatic rand_cycle();
      logic [4:0] a [4];
      for (int i = 0; i < 4; i++)
         a[i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      apply(2'($urandom_range(0, 3)), a[0], $urandom, a[1], $urandom, a[2], a[3],
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
   endtask

   task automatic reset_sweep();
      for (int a = 0; a < 16; a++) begin
         rd_addr = {5'(2*a + 1), 5'(2*a)};
         #1;
         chk("rst_rd_data_byp", rd_data_b, 64'd0);
         chk("rst_rd_data_nob", rd_data_n, 64'd0);
         chk("rst_rd_busy_byp", {62'd0, rd_busy_b}, 64'd0);
      end
      chk("rst_busy_vec_byp", {32'd0, bv_b}, 64'd0);
      chk("rst_busy_vec_nob", {32'd0, bv_n}, 64'd0);
   endtask

   always begin
      exp_t e;
      @(presented);
      #1;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL monitor_underflow: got empty queue expected an entry");
      end else begin
         e = q.pop_front();
         chk("rd_data_byp", rd_data_b, e.d_b);
         chk("rd_data_nob", rd_data_n, e.d_n);
         chk("rd_busy_byp", {62'd0, rd_busy_b}, {62'd0, e.b_b});
         chk("rd_busy_nob", {62'd0, rd_busy_n}, {62'd0, e.b_n});
         chk("busy_vec_byp", {32'd0, bv_b}, {32'd0, e.bv});
         chk("busy_vec_nob", {32'd0, bv_n}, {32'd0, e.bv});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
      model_reset();
      #2;
      reset_sweep();
      @(negedge clk);
      rst_n = 1'b1;

      apply(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
      apply(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
      apply(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
      apply(2'b11, 5'd3, 32'hA, 5'd4, 32'hB, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0);
      apply(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 5'd9, 5'd4, 1'b0, 5'd0, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd6, 1'b1, 5'd6, 1'b0);
      apply(2'b10, 5'd0, 32'h0, 5'd6, 32'h66, 5'd6, 5'd9, 1'b0, 5'd0, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd6, 1'b1, 5'd6, 1'b0);
      apply(2'b01, 5'd6, 32'h77, 5'd0, 32'h0, 5'd6, 5'd7, 1'b1, 5'd6, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd1, 1'b1, 5'd1, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd3, 1'b1, 5'd3, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b1, 5'd4, 1'b1);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd0, 1'b0);
      apply(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0);

      for (int i = 0; i < 1500; i++) rand_cycle();

      // Reset asserted mid-cycle while writes and an issue are pending.
      @(negedge clk);
      wr_en    = 2'b11;
      wr_addr  = {5'd12, 5'd11};
      wr_data  = {32'hCAFE0012, 32'hCAFE0011};
      iss_en   = 1'b1;
      iss_addr = 5'd13;
      flush    = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      wr_en  = '0;
      iss_en = 1'b0;
      model_reset();
      reset_sweep();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) rand_cycle();

      @(negedge clk);
      #2;
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
